// File: rtl/entropy_collector.sv
// entropy_collector
// Samples the ring-oscillator p/n vectors through a two-flop synchronizer,
// reduces each sample to a raw bit pair (a = ^p, b = ^n), applies von Neumann
// debiasing and packs the surviving bits MSB-first into 32-bit words. Words
// are offered on a valid/ack interface. A repetition-count test on the raw
// pairs raises a sticky health_fail.
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-high reset
//   enable       collection enable
//   p, n         16-bit oscillator vectors (asynchronous to clk)
//   rnd_data     conditioned random word, stable while rnd_valid=1
//   rnd_valid    rnd_data holds an unconsumed word
//   rnd_ack      consumer takes the word (ignored while rnd_valid=0)
//   health_fail  sticky repetition-count failure
//   bit_cnt      debiased bits currently held in the shift register (0..32)
//
// state       | meaning
// ------------+-----------------------------------------------------------
// ST_IDLE     | not collecting; shift register and bit_cnt held at zero
// ST_COLLECT  | sampling every SAMPLE_DIV cycles, debiased bits shifted in
// ST_WAIT_OUT | shift register full; waiting for room in rnd_data

module entropy_collector #(
   parameter int SAMPLE_DIV = 8,
   parameter int RCT_CUTOFF = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        enable,
   input  logic [15:0] p,
   input  logic [15:0] n,
   output logic [31:0] rnd_data,
   output logic        rnd_valid,
   input  logic        rnd_ack,
   output logic        health_fail,
   output logic [5:0]  bit_cnt
);

   localparam int CNT_W = $clog2(SAMPLE_DIV);
   localparam int RCT_W = $clog2(RCT_CUTOFF + 1);
   localparam logic [CNT_W-1:0] SMP_LAST = CNT_W'(SAMPLE_DIV - 1);
   localparam logic [RCT_W-1:0] RCT_MAX  = RCT_W'(RCT_CUTOFF);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_COLLECT  = 2'd1,
      ST_WAIT_OUT = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [15:0]      p_s1_q, p_s2_q, n_s1_q, n_s2_q;
   logic [CNT_W-1:0] smp_cnt_q, smp_cnt_d;
   logic [RCT_W-1:0] rct_cnt_q, rct_cnt_d, rct_inc;
   logic [31:0]      shift_q, shift_d;
   logic [5:0]       bit_cnt_q, bit_cnt_d;
   logic [31:0]      rnd_data_q, rnd_data_d;
   logic             rnd_valid_q, rnd_valid_d;
   logic             health_fail_q, health_fail_d;

   logic raw_a, raw_b;
   logic collect_stop, sample, keep, word_full, load, wait_abort;

   // State and datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= ST_IDLE;
         p_s1_q        <= '0;
         p_s2_q        <= '0;
         n_s1_q        <= '0;
         n_s2_q        <= '0;
         smp_cnt_q     <= '0;
         rct_cnt_q     <= '0;
         shift_q       <= '0;
         bit_cnt_q     <= '0;
         rnd_data_q    <= '0;
         rnd_valid_q   <= 1'b0;
         health_fail_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         p_s1_q        <= p;
         p_s2_q        <= p_s1_q;
         n_s1_q        <= n;
         n_s2_q        <= n_s1_q;
         smp_cnt_q     <= smp_cnt_d;
         rct_cnt_q     <= rct_cnt_d;
         shift_q       <= shift_d;
         bit_cnt_q     <= bit_cnt_d;
         rnd_data_q    <= rnd_data_d;
         rnd_valid_q   <= rnd_valid_d;
         health_fail_q <= health_fail_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE: begin
            if (enable && !health_fail_q) state_d = ST_COLLECT;
         end
         ST_COLLECT: begin
            if (collect_stop)   state_d = ST_IDLE;
            else if (word_full) state_d = ST_WAIT_OUT;
         end
         ST_WAIT_OUT: begin
            if (wait_abort) state_d = ST_IDLE;
            else if (load)  state_d = enable ? ST_COLLECT : ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Sampling, debias, health test and output handshake
   always_comb begin
      raw_a        = ^p_s2_q;
      raw_b        = ^n_s2_q;
      collect_stop = (state_q == ST_COLLECT) && (!enable || health_fail_q);
      sample       = (state_q == ST_COLLECT) && !collect_stop && (smp_cnt_q == SMP_LAST);
      keep         = sample && (raw_a != raw_b);
      word_full    = keep && (bit_cnt_q == 6'd31);
      wait_abort   = (state_q == ST_WAIT_OUT) && health_fail_q;
      // A load may replace a word being acked in the same cycle.
      load         = (state_q == ST_WAIT_OUT) && !health_fail_q && (!rnd_valid_q || rnd_ack);

      smp_cnt_d = '0;
      if ((state_q == ST_COLLECT) && !collect_stop && (smp_cnt_q != SMP_LAST)) begin
         smp_cnt_d = smp_cnt_q + 1'b1;
      end

      rct_inc       = (rct_cnt_q == RCT_MAX) ? rct_cnt_q : rct_cnt_q + 1'b1;
      rct_cnt_d     = rct_cnt_q;
      health_fail_d = health_fail_q;
      if (sample) begin
         if (raw_a == raw_b) begin
            rct_cnt_d = rct_inc;
            if (rct_inc == RCT_MAX) health_fail_d = 1'b1;
         end else begin
            rct_cnt_d = '0;
         end
      end

      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      if ((state_q == ST_IDLE) || collect_stop || load || wait_abort) begin
         shift_d   = '0;
         bit_cnt_d = '0;
      end else if (keep) begin
         shift_d   = {shift_q[30:0], raw_a};
         bit_cnt_d = bit_cnt_q + 6'd1;
      end

      rnd_data_d  = rnd_data_q;
      rnd_valid_d = rnd_valid_q;
      if (rnd_valid_q && rnd_ack) rnd_valid_d = 1'b0;
      if (load) begin
         rnd_data_d  = shift_q;
         rnd_valid_d = 1'b1;
      end
   end

   assign rnd_data    = rnd_data_q;
   assign rnd_valid   = rnd_valid_q;
   assign health_fail = health_fail_q;
   assign bit_cnt     = bit_cnt_q;

endmodule
